// File: rtl/zap_memory_main_pkg.sv
// Shared types and helpers for the ZAP memory stage: load-size encodings,
// the registered exception bundle, and the lane rotate/extend primitives.
package zap_memory_main_pkg;

    typedef enum logic [1:0] {
        SZ_WORD     = 2'b00,
        SZ_BYTE     = 2'b01,
        SZ_HALF     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } mem_size_e;

    localparam int LANES      = 4;
    localparam int HALF_LANES = 2;

    // Exceptions travel through the stage as one bundle so flush can clear them at once.
    typedef struct packed {
        logic irq;
        logic fiq;
        logic instr_abt;
        logic data_abt;
        logic swi;
        logic und;
    } exc_t;

    function automatic logic [31:0] ror32(input logic [31:0] d, input logic [4:0] sh);
        logic [63:0] t;
        t = {d, d} >> sh;
        return t[31:0];
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/zap_memory_main_if.sv
// Signal bundle between the execute/data-bus side and the memory stage, and
// from the memory stage to the register file.
interface zap_memory_main_if #(
    parameter int PHY_REGS = 46,
    parameter int FLAG_WDT = 32
);
    localparam int IDX_W = $clog2(PHY_REGS);

    logic                i_clear_from_writeback;
    logic                i_data_stall;
    logic                i_valid;
    logic [31:0]         i_alu_result;
    logic [IDX_W-1:0]    i_wr_index;
    logic [FLAG_WDT-1:0] i_flags;
    logic                i_flag_update;
    logic                i_mem_load;
    logic [IDX_W-1:0]    i_mem_srcdest_index;
    logic [1:0]          i_mem_size;
    logic                i_mem_signed;
    logic [31:0]         i_mem_rd_data;
    logic                i_irq;
    logic                i_fiq;
    logic                i_instr_abt;
    logic                i_swi;
    logic                i_und;
    logic                i_data_abt;
    logic [31:0]         i_pc_buf;

    logic                o_valid;
    logic [IDX_W-1:0]    o_wr_index;
    logic [31:0]         o_wr_data;
    logic [FLAG_WDT-1:0] o_flags;
    logic                o_flag_update_ff;
    logic                o_mem_load_ff;
    logic [IDX_W-1:0]    o_wr_index_1;
    logic [31:0]         o_wr_data_1;
    logic                o_irq;
    logic                o_fiq;
    logic                o_instr_abt;
    logic                o_data_abt;
    logic                o_swi;
    logic                o_und;
    logic [31:0]         o_pc_buf_ff;

    modport slave (
        input  i_clear_from_writeback, i_data_stall, i_valid, i_alu_result, i_wr_index,
               i_flags, i_flag_update, i_mem_load, i_mem_srcdest_index, i_mem_size,
               i_mem_signed, i_mem_rd_data, i_irq, i_fiq, i_instr_abt, i_swi, i_und,
               i_data_abt, i_pc_buf,
        output o_valid, o_wr_index, o_wr_data, o_flags, o_flag_update_ff, o_mem_load_ff,
               o_wr_index_1, o_wr_data_1, o_irq, o_fiq, o_instr_abt, o_data_abt, o_swi,
               o_und, o_pc_buf_ff
    );

    modport master (
        output i_clear_from_writeback, i_data_stall, i_valid, i_alu_result, i_wr_index,
               i_flags, i_flag_update, i_mem_load, i_mem_srcdest_index, i_mem_size,
               i_mem_signed, i_mem_rd_data, i_irq, i_fiq, i_instr_abt, i_swi, i_und,
               i_data_abt, i_pc_buf,
        input  o_valid, o_wr_index, o_wr_data, o_flags, o_flag_update_ff, o_mem_load_ff,
               o_wr_index_1, o_wr_data_1, o_irq, o_fiq, o_instr_abt, o_data_abt, o_swi,
               o_und, o_pc_buf_ff
    );

endinterface

// File: rtl/zap_memory_main_align.sv
// Combinational load aligner: picks the addressed byte/halfword lane and
// extends it, or rotates a whole word for unaligned LDR.
module zap_mem_align
    import zap_memory_main_pkg::*;
(
    input  logic [31:0] rd_data_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane [LANES];
    logic [15:0] half [HALF_LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane[gi] = rd_data_i[8*gi +: 8];
    end

    for (genvar gi = 0; gi < HALF_LANES; gi++) begin : g_half
        assign half[gi] = rd_data_i[16*gi +: 16];
    end

    // Halfword accesses ignore addr[0]; encoding 2'b11 falls back to word.
    always_comb begin
        data_o = ror32(rd_data_i, {addr_i, 3'b000});
        case (mem_size_e'(size_i))
            SZ_BYTE: data_o = ext8(lane[addr_i], signed_i);
            SZ_HALF: data_o = ext16(half[addr_i[1]], signed_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/zap_memory_main.sv
// ZAP memory stage: single pipeline register in front of the register file,
// merging aligned load data and exception indicators under stall/flush control.
module zap_memory_main
    import zap_memory_main_pkg::*;
#(
    parameter int PHY_REGS = 46,
    parameter int FLAG_WDT = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    zap_memory_main_if.slave bus
);

    localparam int IDX_W = $clog2(PHY_REGS);

    logic                valid_q,        valid_d;
    logic [IDX_W-1:0]    wr_index_q,     wr_index_d;
    logic [31:0]         wr_data_q,      wr_data_d;
    logic [FLAG_WDT-1:0] flags_q,        flags_d;
    logic                flag_update_q,  flag_update_d;
    logic                mem_load_q,     mem_load_d;
    logic [IDX_W-1:0]    wr_index_1_q,   wr_index_1_d;
    logic [31:0]         wr_data_1_q,    wr_data_1_d;
    exc_t                exc_q,          exc_d;
    logic [31:0]         pc_buf_q,       pc_buf_d;

    logic [31:0] aligned_data;
    logic        data_abt_hit;

    zap_mem_align u_align (
        .rd_data_i (bus.i_mem_rd_data),
        .addr_i    (bus.i_alu_result[1:0]),
        .size_i    (bus.i_mem_size),
        .signed_i  (bus.i_mem_signed),
        .data_o    (aligned_data)
    );

    // An abort only counts for a load or a valid store; otherwise it is noise.
    assign data_abt_hit = bus.i_data_abt & (bus.i_mem_load | bus.i_valid);

    always_comb begin
        valid_d       = valid_q;
        wr_index_d    = wr_index_q;
        wr_data_d     = wr_data_q;
        flags_d       = flags_q;
        flag_update_d = flag_update_q;
        mem_load_d    = mem_load_q;
        wr_index_1_d  = wr_index_1_q;
        wr_data_1_d   = wr_data_1_q;
        exc_d         = exc_q;
        pc_buf_d      = pc_buf_q;

        if (bus.i_clear_from_writeback) begin
            valid_d       = 1'b0;
            flag_update_d = 1'b0;
            mem_load_d    = 1'b0;
            exc_d         = '0;
        end else if (!bus.i_data_stall) begin
            valid_d         = bus.i_valid;
            wr_index_d      = bus.i_wr_index;
            wr_data_d       = bus.i_alu_result;
            flags_d         = bus.i_flags;
            flag_update_d   = bus.i_flag_update;
            mem_load_d      = bus.i_mem_load & bus.i_valid & ~data_abt_hit;
            wr_index_1_d    = bus.i_mem_srcdest_index;
            wr_data_1_d     = aligned_data;
            pc_buf_d        = bus.i_pc_buf;
            exc_d.irq       = bus.i_irq;
            exc_d.fiq       = bus.i_fiq;
            exc_d.instr_abt = bus.i_instr_abt;
            exc_d.data_abt  = data_abt_hit;
            exc_d.swi       = bus.i_swi;
            exc_d.und       = bus.i_und;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q       <= 1'b0;
            wr_index_q    <= '0;
            wr_data_q     <= '0;
            flags_q       <= '0;
            flag_update_q <= 1'b0;
            mem_load_q    <= 1'b0;
            wr_index_1_q  <= '0;
            wr_data_1_q   <= '0;
            exc_q         <= '0;
            pc_buf_q      <= '0;
        end else begin
            valid_q       <= valid_d;
            wr_index_q    <= wr_index_d;
            wr_data_q     <= wr_data_d;
            flags_q       <= flags_d;
            flag_update_q <= flag_update_d;
            mem_load_q    <= mem_load_d;
            wr_index_1_q  <= wr_index_1_d;
            wr_data_1_q   <= wr_data_1_d;
            exc_q         <= exc_d;
            pc_buf_q      <= pc_buf_d;
        end
    end

    assign bus.o_valid          = valid_q;
    assign bus.o_wr_index       = wr_index_q;
    assign bus.o_wr_data        = wr_data_q;
    assign bus.o_flags          = flags_q;
    assign bus.o_flag_update_ff = flag_update_q;
    assign bus.o_mem_load_ff    = mem_load_q;
    assign bus.o_wr_index_1     = wr_index_1_q;
    assign bus.o_wr_data_1      = wr_data_1_q;
    assign bus.o_irq            = exc_q.irq;
    assign bus.o_fiq            = exc_q.fiq;
    assign bus.o_instr_abt      = exc_q.instr_abt;
    assign bus.o_data_abt       = exc_q.data_abt;
    assign bus.o_swi            = exc_q.swi;
    assign bus.o_und            = exc_q.und;
    assign bus.o_pc_buf_ff      = pc_buf_q;

endmodule
